// File: rtl/scr1_dmem_arb2.sv
// Two-requester arbiter for the shared data-memory port (m0 = core LSU, m1 = debug/DMA).
// Latency: zero-cycle request pass-through. Responses are routed to the owner of the single outstanding transaction.
// Backpressure: the loser, and any requester while the window is closed, sees req_ack=0 and must hold its request.
// Optional feature: define SCR1_DMEM_ARB_RR_EN for round-robin. Otherwise m0 has fixed priority with a burst limit.

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module scr1_dmem_arb2 #(
    parameter int SCR1_ARB_BURST_MAX = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          m0_req,
    output logic                          m0_req_ack,
    input  logic                          m0_cmd,
    input  logic [1:0]                    m0_width,
    input  logic [`SCR1_DMEM_AWIDTH-1:0]  m0_addr,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]  m0_wdata,
    output logic [`SCR1_DMEM_DWIDTH-1:0]  m0_rdata,
    output logic [1:0]                    m0_resp,

    input  logic                          m1_req,
    output logic                          m1_req_ack,
    input  logic                          m1_cmd,
    input  logic [1:0]                    m1_width,
    input  logic [`SCR1_DMEM_AWIDTH-1:0]  m1_addr,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]  m1_wdata,
    output logic [`SCR1_DMEM_DWIDTH-1:0]  m1_rdata,
    output logic [1:0]                    m1_resp,

    output logic                          slv_req,
    input  logic                          slv_req_ack,
    output logic                          slv_cmd,
    output logic [1:0]                    slv_width,
    output logic [`SCR1_DMEM_AWIDTH-1:0]  slv_addr,
    output logic [`SCR1_DMEM_DWIDTH-1:0]  slv_wdata,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]  slv_rdata,
    input  logic [1:0]                    slv_resp
);

    // Memory response encoding: NOTRDY / RDY_OK / RDY_ER
    localparam logic [1:0] RESP_NOTRDY = 2'd0;
    localparam logic [1:0] RESP_RDY_OK = 2'd1;
    localparam logic [1:0] RESP_RDY_ER = 2'd2;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [3:0] BURST_MAX = 4'(SCR1_ARB_BURST_MAX);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_owner;
    logic        r_last_grant;
    logic [3:0]  r_burst_cnt;

    logic        w_window;
    logic        w_any_req;
    logic        w_winner;
    logic        w_accept;
    logic [3:0]  w_burst_nxt;

    // A new request may be granted when idle, or when the outstanding one completes OK.
    assign w_window  = (r_state == ST_IDLE) ||
                       ((r_state == ST_DATA) && (slv_resp == RESP_RDY_OK));
    assign w_any_req = m0_req | m1_req;
    assign w_accept  = rst_n & w_window & w_any_req & slv_req_ack;

    // Winner selection; only meaningful when at least one requester is active.
`ifdef SCR1_DMEM_ARB_RR_EN
    always_comb begin
        if (m0_req && m1_req) begin
            w_winner = ~r_last_grant;
        end else begin
            w_winner = m1_req ? M1 : M0;
        end
    end
`else
    always_comb begin
        w_winner = M0;
        if (m1_req && (!m0_req || ((r_last_grant == M0) && (r_burst_cnt == BURST_MAX)))) begin
            w_winner = M1;
        end
    end
`endif

    // Burst counter: saturating count of consecutive grants to the same requester.
    always_comb begin
        w_burst_nxt = 4'd1;
        if (w_winner == r_last_grant) begin
            w_burst_nxt = (r_burst_cnt < BURST_MAX) ? (r_burst_cnt + 4'd1) : BURST_MAX;
        end
    end

    // Slave command fields follow the winner combinationally.
    assign slv_cmd   = (w_winner == M1) ? m1_cmd   : m0_cmd;
    assign slv_width = (w_winner == M1) ? m1_width : m0_width;
    assign slv_addr  = (w_winner == M1) ? m1_addr  : m0_addr;
    assign slv_wdata = (w_winner == M1) ? m1_wdata : m0_wdata;

    // Next state, request/ack gating and response routing; reset forces everything quiet.
    always_comb begin
        w_state_nxt = r_state;
        slv_req     = 1'b0;
        m0_req_ack  = 1'b0;
        m1_req_ack  = 1'b0;
        m0_resp     = RESP_NOTRDY;
        m1_resp     = RESP_NOTRDY;
        m0_rdata    = '0;
        m1_rdata    = '0;
        if (rst_n) begin
            if (w_window) begin
                slv_req    = w_any_req;
                m0_req_ack = w_any_req & (w_winner == M0) & slv_req_ack;
                m1_req_ack = w_any_req & (w_winner == M1) & slv_req_ack;
            end
            if (r_state == ST_DATA) begin
                if (r_owner == M1) begin
                    m1_resp  = slv_resp;
                    m1_rdata = slv_rdata;
                end else begin
                    m0_resp  = slv_resp;
                    m0_rdata = slv_rdata;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) w_state_nxt = ST_DATA;
                end
                ST_DATA: begin
                    if (slv_resp == RESP_RDY_OK) begin
                        w_state_nxt = w_accept ? ST_DATA : ST_IDLE;
                    end else if (slv_resp == RESP_RDY_ER) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, owner and fairness bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= M0;
            r_last_grant <= M1;
            r_burst_cnt  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
                r_burst_cnt  <= w_burst_nxt;
            end
        end
    end

endmodule

// File: tb/tb_scr1_dmem_arb2.sv
// Directed bench for scr1_dmem_arb2 in its default (fixed-priority, burst 4) build.
// Latency: one table row per clock. Inputs are driven 1 ns after the rising edge and checked on the falling edge.
// Backpressure: slv_req_ack is driven directly from the vectors.

module tb_scr1_dmem_arb2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req;
    logic        m0_req_ack, m1_req_ack;
    logic        m0_cmd, m1_cmd;
    logic [1:0]  m0_width, m1_width;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_resp, m1_resp;
    logic        slv_req, slv_req_ack, slv_cmd;
    logic [1:0]  slv_width, slv_resp;
    logic [31:0] slv_addr, slv_wdata, slv_rdata;

    always #5 clk = ~clk;

    scr1_dmem_arb2 #(.SCR1_ARB_BURST_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_req_ack(m0_req_ack), .m0_cmd(m0_cmd), .m0_width(m0_width),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
        .m1_req(m1_req), .m1_req_ack(m1_req_ack), .m1_cmd(m1_cmd), .m1_width(m1_width),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
        .slv_req(slv_req), .slv_req_ack(slv_req_ack), .slv_cmd(slv_cmd), .slv_width(slv_width),
        .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_resp(slv_resp)
    );

    localparam logic [1:0] NR = 2'd0;  // NOTRDY
    localparam logic [1:0] OK = 2'd1;  // RDY_OK
    localparam logic [1:0] ER = 2'd2;  // RDY_ER
    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;

    typedef struct {
        logic        rst_n, m0, m1, ack;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        e_req, e_a0, e_a1;
        logic [31:0] e_addr;
        logic [1:0]  e_r0, e_r1;
        logic [31:0] e_d0, e_d1;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   row   = -1;

    function automatic void add(logic r, logic q0, logic q1, logic ack, logic [1:0] resp,
                                logic [31:0] rd, logic e_req, logic e_a0, logic e_a1,
                                logic [31:0] e_addr, logic [1:0] e_r0, logic [1:0] e_r1,
                                logic [31:0] e_d0, logic [31:0] e_d1);
        vec_t v;
        v.rst_n = r; v.m0 = q0; v.m1 = q1; v.ack = ack; v.resp = resp; v.rdata = rd;
        v.e_req = e_req; v.e_a0 = e_a0; v.e_a1 = e_a1; v.e_addr = e_addr;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_d0 = e_d0; v.e_d1 = e_d1;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic chk_outputs(input vec_t v);
        chk("slv_req",    {31'd0, slv_req},    {31'd0, v.e_req});
        chk("m0_req_ack", {31'd0, m0_req_ack}, {31'd0, v.e_a0});
        chk("m1_req_ack", {31'd0, m1_req_ack}, {31'd0, v.e_a1});
        chk("slv_addr",   slv_addr,            v.e_addr);
        chk("m0_resp",    {30'd0, m0_resp},    {30'd0, v.e_r0});
        chk("m1_resp",    {30'd0, m1_resp},    {30'd0, v.e_r1});
        chk("m0_rdata",   m0_rdata,            v.e_d0);
        chk("m1_rdata",   m1_rdata,            v.e_d1);
    endtask

    initial begin
        rst_n = 1'b0; m0_req = 1'b1; m1_req = 1'b0; slv_req_ack = 1'b1;
        slv_resp = OK; slv_rdata = 32'hFFFF_FFFF;
        m0_cmd = 1'b0; m0_width = 2'd2; m0_addr = A0; m0_wdata = 32'h0000_000A;
        m1_cmd = 1'b1; m1_width = 2'd1; m1_addr = A1; m1_wdata = 32'h0000_000B;

        // Reset held: everything quiet even with a live request and an OK response.
        @(negedge clk);
        chk("rst_slv_req", {31'd0, slv_req},    32'd0);
        chk("rst_m0_ack",  {31'd0, m0_req_ack}, 32'd0);
        chk("rst_m0_resp", {30'd0, m0_resp},    32'd0);
        chk("rst_m0_rdata", m0_rdata,           32'd0);
        @(posedge clk);
        @(posedge clk);

        //  rst m0 m1 ack resp rdata          req a0 a1 addr r0  r1  d0            d1
        // Single m0 read: accepted, two NOTRDY, then RDY_OK, then idle.
        add(1, 1, 0, 1, NR, 32'h0,         1, 1, 0, A0, NR, NR, 32'h0,         32'h0);
        add(1, 0, 0, 1, NR, 32'h0,         0, 0, 0, A0, NR, NR, 32'h0,         32'h0);
        add(1, 0, 0, 1, NR, 32'h0,         0, 0, 0, A0, NR, NR, 32'h0,         32'h0);
        add(1, 0, 0, 1, OK, 32'hDEADBEEF,  0, 0, 0, A0, OK, NR, 32'hDEADBEEF,  32'h0);
        add(1, 0, 0, 1, OK, 32'hDEADBEEF,  0, 0, 0, A0, NR, NR, 32'h0,         32'h0);
        // Both requesting, OK every cycle: last_grant=m0, cnt=1 -> m0 m0 m0 m1 m0 m0 m0 m0 m1.
        add(1, 1, 1, 1, OK, 32'h11,        1, 1, 0, A0, NR, NR, 32'h0,         32'h0);
        add(1, 1, 1, 1, OK, 32'h11,        1, 1, 0, A0, OK, NR, 32'h11,        32'h0);
        add(1, 1, 1, 1, OK, 32'h11,        1, 1, 0, A0, OK, NR, 32'h11,        32'h0);
        add(1, 1, 1, 1, OK, 32'h11,        1, 0, 1, A1, OK, NR, 32'h11,        32'h0);
        add(1, 1, 1, 1, OK, 32'h11,        1, 1, 0, A0, NR, OK, 32'h0,         32'h11);
        add(1, 1, 1, 1, OK, 32'h11,        1, 1, 0, A0, OK, NR, 32'h11,        32'h0);
        add(1, 1, 1, 1, OK, 32'h11,        1, 1, 0, A0, OK, NR, 32'h11,        32'h0);
        add(1, 1, 1, 1, OK, 32'h11,        1, 1, 0, A0, OK, NR, 32'h11,        32'h0);
        add(1, 1, 1, 1, OK, 32'h11,        1, 0, 1, A1, OK, NR, 32'h11,        32'h0);
        // Owner m1 gets RDY_ER with m0 waiting: no ack that cycle, m0 accepted from idle next.
        add(1, 1, 0, 1, ER, 32'h22,        0, 0, 0, A0, NR, ER, 32'h0,         32'h22);
        add(1, 1, 0, 1, NR, 32'h0,         1, 1, 0, A0, NR, NR, 32'h0,         32'h0);
        add(1, 0, 0, 1, OK, 32'h33,        0, 0, 0, A0, OK, NR, 32'h33,        32'h0);
        // Both request, slave stalls three cycles, then accepts m0 once.
        add(1, 1, 1, 0, NR, 32'h0,         1, 0, 0, A0, NR, NR, 32'h0,         32'h0);
        add(1, 1, 1, 0, NR, 32'h0,         1, 0, 0, A0, NR, NR, 32'h0,         32'h0);
        add(1, 1, 1, 0, NR, 32'h0,         1, 0, 0, A0, NR, NR, 32'h0,         32'h0);
        add(1, 1, 1, 1, NR, 32'h0,         1, 1, 0, A0, NR, NR, 32'h0,         32'h0);
        add(1, 0, 0, 1, OK, 32'h44,        0, 0, 0, A0, OK, NR, 32'h44,        32'h0);
        // m1 owns, then reset for one edge: owner dropped, first contention goes to m0.
        add(1, 0, 1, 1, NR, 32'h0,         1, 0, 1, A1, NR, NR, 32'h0,         32'h0);
        add(0, 1, 1, 1, OK, 32'h55,        0, 0, 0, A0, NR, NR, 32'h0,         32'h0);
        add(1, 1, 1, 1, OK, 32'h66,        1, 1, 0, A0, NR, NR, 32'h0,         32'h0);
        add(1, 0, 0, 1, OK, 32'h77,        0, 0, 0, A0, OK, NR, 32'h77,        32'h0);
        // m1 withdraws before ack: no slave request, no transaction started.
        add(1, 0, 1, 0, NR, 32'h0,         1, 0, 0, A1, NR, NR, 32'h0,         32'h0);
        add(1, 0, 0, 1, NR, 32'h0,         0, 0, 0, A0, NR, NR, 32'h0,         32'h0);
        add(1, 0, 0, 1, OK, 32'h88,        0, 0, 0, A0, NR, NR, 32'h0,         32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            row = i;
            rst_n = vq[i].rst_n; m0_req = vq[i].m0; m1_req = vq[i].m1;
            slv_req_ack = vq[i].ack; slv_resp = vq[i].resp; slv_rdata = vq[i].rdata;
            @(negedge clk);
            chk_outputs(vq[i]);
        end

        // Command fields follow the winner with zero latency (slave stalling, idle state).
        @(posedge clk);
        #1;
        row = 1000;
        m0_req = 1'b0; m1_req = 1'b1; slv_req_ack = 1'b0; slv_resp = NR;
        m1_cmd = 1'b1; m1_width = 2'd2; m1_wdata = 32'hCAFE_0001;
        m0_cmd = 1'b0; m0_width = 2'd0; m0_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("m1_slv_cmd",   {31'd0, slv_cmd},   32'd1);
        chk("m1_slv_width", {30'd0, slv_width}, 32'd2);
        chk("m1_slv_wdata", slv_wdata,          32'hCAFE_0001);
        #1;
        row = 1001;
        m0_req = 1'b1;
        #1;
        chk("m0_slv_cmd",   {31'd0, slv_cmd},   32'd0);
        chk("m0_slv_width", {30'd0, slv_width}, 32'd0);
        chk("m0_slv_wdata", slv_wdata,          32'h1234_5678);
        chk("m0_slv_addr",  slv_addr,           A0);
        m0_req = 1'b0; m1_req = 1'b0;
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog: the bench is purely cycle-driven, so this only fires if the clock stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/scr1_dmem_arb2.md
SCR1_DMEM_ARB2 -- requirements
Module: scr1_dmem_arb2

Interface
REQ-001 Parameter SCR1_ARB_BURST_MAX, default 4: max consecutive grants to the priority requester (m0) while m1 waits; range 1..15.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 m0_req / m1_req  input  1  requester address-phase request (m0 = core LSU, m1 = debug/DMA).
REQ-005 m0_req_ack / m1_req_ack  output  1  request accepted this cycle.
REQ-006 mX_cmd  input  type_scr1_mem_cmd_e; mX_width  input  type_scr1_mem_width_e; mX_addr  input  `SCR1_DMEM_AWIDTH; mX_wdata  input  `SCR1_DMEM_DWIDTH (X = 0,1).
REQ-007 mX_rdata  output  `SCR1_DMEM_DWIDTH; mX_resp  output  type_scr1_mem_resp_e (X = 0,1).
REQ-008 slv_req  output  1; slv_req_ack  input  1; slv_cmd, slv_width, slv_addr, slv_wdata  outputs, same types/widths as requester side; slv_rdata  input; slv_resp  input: shared dmem port.

Function
REQ-009 State machine SHALL have two states: IDLE (nothing outstanding), DATA (one transaction outstanding, owner register valid).
REQ-010 Grant window SHALL be open when state==IDLE, or state==DATA and slv_resp==SCR1_MEM_RESP_RDY_OK; closed otherwise.
REQ-011 Window open: slv_req = m0_req | m1_req; slv_cmd/width/addr/wdata SHALL combinationally carry the winner's fields, zero-latency.
REQ-012 Window closed: slv_req=0, both mX_req_ack=0.
REQ-013 Single requester active SHALL win.
REQ-014 Both active: winner per REQ-025/REQ-026.
REQ-015 Winner's mX_req_ack = slv_req_ack; loser's mX_req_ack=0; loser must hold its request.
REQ-016 Accept (slv_req & slv_req_ack in open window): owner<=winner, last_grant<=winner, state<=DATA.
REQ-017 burst_cnt on accept: winner==last_grant -> saturating increment to SCR1_ARB_BURST_MAX; else -> 1.
REQ-018 DATA: slv_rdata/slv_resp SHALL route to owner's mX_rdata/mX_resp; non-owner sees SCR1_MEM_RESP_NOTRDY, rdata '0.
REQ-019 IDLE: both mX_resp = NOTRDY, rdata '0.
REQ-020 DATA + RDY_OK with no new accept -> IDLE; with new accept -> stays DATA, owner updated (back-to-back, no bubble).
REQ-021 DATA + RDY_ER -> IDLE; no accept that cycle (window closed).
REQ-022 DATA + NOTRDY -> stays DATA, owner unchanged.
REQ-023 Requester dropping req before ack SHALL produce no slave request when the other is idle.

Reset
REQ-024 rst_n low at clk edge: state=IDLE, owner=m0, last_grant=m1, burst_cnt=0; while rst_n low slv_req=0, mX_req_ack=0, mX_resp=NOTRDY, mX_rdata='0; reset mid-transaction discards outstanding owner (slave reset jointly).

Configuration
REQ-025 SCR1_DMEM_ARB_RR_EN defined: round-robin; both active -> requester != last_grant wins; SCR1_ARB_BURST_MAX unused.
REQ-026 SCR1_DMEM_ARB_RR_EN undefined: fixed priority m0, except m1 wins when last_grant==m0 and burst_cnt==SCR1_ARB_BURST_MAX and m1_req=1.

Verification
REQ-027 Single m0 read, slv_req_ack=1, resp NOTRDY x2 then RDY_OK rdata=0xDEADBEEF -> m0_req_ack 1 cycle, m0_resp RDY_OK with 0xDEADBEEF on cycle 3, m1_resp NOTRDY throughout, state IDLE after.
REQ-028 RR_EN, m0/m1 both request continuously, resp RDY_OK every cycle -> grants m0,m1,m0,m1 back-to-back, no idle cycle.
REQ-029 RR_EN undefined, BURST_MAX=4, both requesting, resp RDY_OK each cycle -> grants m0 x4, m1 x1, m0 x4, ...
REQ-030 Owner m1 gets RDY_ER while m0_req=1 -> m1_resp RDY_ER, m0_req_ack=0 that cycle, m0 accepted next cycle from IDLE.
REQ-031 Both request, slv_req_ack=0 for 3 cycles -> slv_addr tracks winner, no mX_req_ack, state stays IDLE; ack on cycle 4 -> winner acked once.
REQ-032 rst_n low for one edge while DATA/owner m1 -> next cycle IDLE, outputs at reset values, first post-reset contention grants m0.
